// File: rtl/dma_burst_sequencer.sv
// dma_burst_sequencer: splits a DMA transfer into AXI bursts (<= MAX_BURST_BEATS, no 4 KB crossing), read then write per burst
module dma_burst_sequencer #(
    parameter int DATA_BYTES      = 4,
    parameter int MAX_BURST_BEATS = 16
) (
    input  logic        S_AXI_ACLK,
    input  logic        S_AXI_ARESETN,
    input  logic        i_dma_start,
    input  logic [31:0] i_src_addr,
    input  logic [31:0] i_dst_addr,
    input  logic [31:0] i_trf_len,
    output logic        o_dma_done,
    output logic        o_dma_err,
    output logic        o_busy,
    output logic        o_rd_cmd_valid,
    input  logic        i_rd_cmd_ready,
    output logic [31:0] o_rd_cmd_addr,
    output logic [7:0]  o_rd_cmd_len,
    input  logic        i_rd_burst_done,
    input  logic        i_rd_err,
    output logic        o_wr_cmd_valid,
    input  logic        i_wr_cmd_ready,
    output logic [31:0] o_wr_cmd_addr,
    output logic [7:0]  o_wr_cmd_len,
    input  logic        i_wr_burst_done,
    input  logic        i_wr_err
);
    typedef enum logic [2:0] {IDLE, CALC, RD_CMD, RD_WAIT, WR_CMD, WR_WAIT, DONE} state_t;
    state_t      state;
    logic [31:0] src, dst;
    logic [30:0] rem;
    logic [7:0]  blen;
    logic [31:0] cap_s, cap_d, m0, m1, bsel, step;
    logic [7:0]  blen_next;

    // next burst size: smallest of remaining beats, the burst cap and the beats left before each 4 KB page ends
    always_comb begin
        cap_s     = 32'd1024 - {22'd0, src[11:2]};
        cap_d     = 32'd1024 - {22'd0, dst[11:2]};
        m0        = ({1'b0, rem} < 32'(MAX_BURST_BEATS)) ? {1'b0, rem} : 32'(MAX_BURST_BEATS);
        m1        = (m0 < cap_s) ? m0 : cap_s;
        bsel      = (m1 < cap_d) ? m1 : cap_d;
        blen_next = 8'(bsel - 32'd1);
        step      = ({24'd0, blen} + 32'd1) * 32'(DATA_BYTES);
    end

    // sequencing FSM with registered command and status outputs
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            state          <= IDLE;
            src            <= '0;
            dst            <= '0;
            rem            <= '0;
            blen           <= '0;
            o_dma_done     <= 1'b0;
            o_dma_err      <= 1'b0;
            o_busy         <= 1'b0;
            o_rd_cmd_valid <= 1'b0;
            o_rd_cmd_addr  <= '0;
            o_rd_cmd_len   <= '0;
            o_wr_cmd_valid <= 1'b0;
            o_wr_cmd_addr  <= '0;
            o_wr_cmd_len   <= '0;
        end else begin
            case (state)
                IDLE: if (i_dma_start) begin
                    src    <= i_src_addr & ~32'd3;
                    dst    <= i_dst_addr & ~32'd3;
                    rem    <= {1'b0, i_trf_len[31:2]} + {30'd0, |i_trf_len[1:0]};
                    o_busy <= 1'b1;
                    state  <= CALC;
                end
                CALC: if (rem == '0) begin
                    o_busy     <= 1'b0;
                    o_dma_done <= 1'b1;
                    o_dma_err  <= 1'b0;
                    state      <= DONE;
                end else begin
                    blen           <= blen_next;
                    o_rd_cmd_valid <= 1'b1;
                    o_rd_cmd_addr  <= src;
                    o_rd_cmd_len   <= blen_next;
                    state          <= RD_CMD;
                end
                RD_CMD: if (i_rd_cmd_ready) begin
                    o_rd_cmd_valid <= 1'b0;
                    state          <= RD_WAIT;
                end
                RD_WAIT: if (i_rd_burst_done) begin
                    if (i_rd_err) begin
                        o_busy     <= 1'b0;
                        o_dma_done <= 1'b1;
                        o_dma_err  <= 1'b1;
                        state      <= DONE;
                    end else begin
                        o_wr_cmd_valid <= 1'b1;
                        o_wr_cmd_addr  <= dst;
                        o_wr_cmd_len   <= blen;
                        state          <= WR_CMD;
                    end
                end
                WR_CMD: if (i_wr_cmd_ready) begin
                    o_wr_cmd_valid <= 1'b0;
                    state          <= WR_WAIT;
                end
                WR_WAIT: if (i_wr_burst_done) begin
                    if (i_wr_err) begin
                        o_busy     <= 1'b0;
                        o_dma_done <= 1'b1;
                        o_dma_err  <= 1'b1;
                        state      <= DONE;
                    end else begin
                        src   <= src + step;
                        dst   <= dst + step;
                        rem   <= rem - ({23'd0, blen} + 31'd1);
                        state <= CALC;
                    end
                end
                DONE: if (!i_dma_start) begin
                    o_dma_done <= 1'b0;
                    o_dma_err  <= 1'b0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
